cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
Programmable CPU clock generator and run-control unit between the board clock and the cpu core. Divides clk by a runtime-loadable even ratio and produces the CPU clock plus a matching single-cycle rising-edge strobe. Supports run, halt and debounced single-step modes for board-level debugging. Replaces the fixed divide-by-4 toggle logic in the top level.

Parameters:
HALF_W, 8, width of the half-period register and counter
HALF_DEFAULT, 2, half-period in clk cycles after reset; 2 gives divide-by-4
DEB_CYCLES, 16, consecutive stable clk cycles required to accept a step_btn level change
DEB_W, 5, width of the debounce counter; must hold DEB_CYCLES

Ports:
clk  in  1  board clock
reset  in  1  synchronous, active-high reset
half_in  in  HALF_W  new half-period value
half_load  in  1  one-cycle pulse; captures half_in
mode  in  2  00 run, 01 halt, 10 step, 11 treated as halt
step_btn  in  1  raw asynchronous push button
cpu_clk  out  1  divided CPU clock
cpu_ce  out  1  one-clk pulse in the first clk cycle that cpu_clk is 1
halted  out  1  1 when cpu_clk is parked low and no period is in progress
cpu_cycles  out  32  count of cpu_clk rising edges (see Optional Feature)

Behaviour:
- Reset values: cpu_clk=0, cpu_ce=0, halted=1, cpu_cycles=0. Internal state: cnt=0, half_reg=HALF_DEFAULT, pending cleared, debounce state 0, sync FFs 0.
- Reset has priority over all other inputs in every cycle. Asserting reset mid-period truncates the pulse immediately; no completion is owed.
- Divider:
  - In run, cnt increments every clk cycle.
  - When cnt==eff_half-1, cnt returns to 0 and cpu_clk toggles in the same edge.
  - eff_half = max(half_reg, 1). Period is 2*eff_half clk cycles at 50% duty.
  - With HALF_DEFAULT=2 after reset release: cpu_clk rises at the 2nd clk edge and falls at the 4th.
- cpu_ce is registered and asserted on the same edge where cpu_clk goes 0->1. It is never high for two consecutive cycles.
- half_load: half_in is stored in a pending register and applied to half_reg only on the next edge where cpu_clk goes 1->0, so no shortened half-period is ever produced. A second load before that edge overwrites pending. A load while parked (halted=1) applies on the next edge.
- Halt (mode 01/11):
  - If cpu_clk=1, the high half completes normally and cpu_clk falls; it then parks low, with cnt=0 and halted=1 on the following edge.
  - If cpu_clk=0 in the middle of the low half, that half also completes before parking. No runt pulses are produced.
- Run resumption from parked: cnt restarts at 0, and the first rise occurs eff_half cycles later. halted drops on the first counting edge.
- Step (mode 10):
  - step_btn is passed through a 2-FF synchroniser, then the debouncer.
  - The debounced level changes only after DEB_CYCLES consecutive identical synchronised samples.
  - A 0->1 transition of the debounced level requests exactly one full period: high half then low half. After that period the clock parks low.
  - Requests arriving while a step period is in progress are dropped, not queued.
  - Entering step from run behaves like halt until a request arrives.
- Mode changes mid-period always complete the current full period before the new mode takes effect.
- Divider state, pending and step requests are fully synchronous to clk; only step_btn is asynchronous.

Optional Feature:
CPU_CYCLE_COUNT_EN
- Defined: cpu_cycles is a 32-bit counter incremented on every cpu_ce. It wraps 0xFFFFFFFF->0 and is cleared only by reset.
- Undefined: cpu_cycles is driven constant 0 and no counter flops are inferred; the port remains present.

Test Plan:
- Reset release with mode=00 and no load -> cpu_clk period 4 clk; cpu_ce high exactly 1 cycle per period, coinciding with the rise 2 cycles after release; halted=0 after the first edge.
- half_in=5 loaded mid-high-phase -> current period stays 4; starting from the next falling edge, period is 10 clk with 5 high / 5 low. half_in=0 loaded -> period 2.
- mode 00->01 with cpu_clk=1 and 1 cycle into the high half -> high half lasts full length, cpu_clk then low forever, halted=1, no further cpu_ce; back to 00 -> first rise 2 cycles later.
- mode=10, step_btn bouncing for 10 cycles then held 1 for 40 cycles (DEB_CYCLES=16) -> exactly one cpu_ce and one 4-cycle period; second press during that period -> ignored; press after it -> one more period.
- reset asserted while cpu_clk=1 -> cpu_clk=0, cpu_ce=0, halted=1 at the next edge, half_reg back to 2.
- With CPU_CYCLE_COUNT_EN, run 100 periods -> cpu_cycles=100; without the macro -> cpu_cycles=0 throughout.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// CPU clock divider with run/halt/debounced single-step control; outputs registered, 1 clk latency.
// Optional macro CPU_CYCLE_COUNT_EN enables the cpu_cycles rising-edge counter.
module cpu_clk_ctrl #(
  parameter int HALF_W       = 8,
  parameter int HALF_DEFAULT = 2,
  parameter int DEB_CYCLES   = 16,
  parameter int DEB_W        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HALF_W-1:0] half_in,
  input  logic              half_load,
  input  logic [1:0]        mode,
  input  logic              step_btn,
  output logic              cpu_clk,
  output logic              cpu_ce,
  output logic              halted,
  output logic [31:0]       cpu_cycles
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] half_reg;
  logic [HALF_W-1:0] pend_half;
  logic              pend_vld;
  logic              step_active;

  logic              sync1, sync2;
  logic              deb_lvl;
  logic [DEB_W-1:0]  deb_cnt;
  logic              step_req;

  logic [HALF_W-1:0] eff_m1;
  logic              run, step_mode, at_end, park, fall_now;

  assign run       = (mode == 2'b00);
  assign step_mode = (mode == 2'b10);
  assign eff_m1    = (half_reg == '0) ? '0 : half_reg - 1'b1;
  assign at_end    = (cnt == eff_m1);

  // Stop only while low: at the start of a low half, or once it has fully elapsed.
  // A step period always plays its low half out before parking.
  assign park = !halted && !cpu_clk &&
                (step_active ? at_end : (!run && (cnt == '0 || at_end)));
  assign fall_now = !halted && cpu_clk && at_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb_lvl  <= 1'b0;
      deb_cnt  <= '0;
      step_req <= 1'b0;
    end else begin
      sync1    <= step_btn;
      sync2    <= sync1;
      step_req <= 1'b0;
      if (sync2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt  <= '0;
        deb_lvl  <= sync2;
        step_req <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // New half-period takes effect only at a falling edge or while parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_reg  <= HALF_W'(HALF_DEFAULT);
      pend_half <= '0;
      pend_vld  <= 1'b0;
    end else begin
      if (pend_vld && (fall_now || halted)) begin
        half_reg <= pend_half;
      end
      if (half_load) begin
        pend_half <= half_in;
        pend_vld  <= 1'b1;
      end else if (fall_now || halted) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      cpu_clk     <= 1'b0;
      cpu_ce      <= 1'b0;
      halted      <= 1'b1;
      step_active <= 1'b0;
    end else begin
      cpu_ce <= 1'b0;
      if (halted) begin
        if (run) begin
          halted <= 1'b0;
          if (at_end) begin
            cnt     <= '0;
            cpu_clk <= 1'b1;
            cpu_ce  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else if (step_mode && step_req) begin
          // A step starts with its high half straight away.
          halted      <= 1'b0;
          step_active <= 1'b1;
          cnt         <= '0;
          cpu_clk     <= 1'b1;
          cpu_ce      <= 1'b1;
        end
      end else if (park) begin
        halted      <= 1'b1;
        step_active <= 1'b0;
        cnt         <= '0;
      end else if (at_end) begin
        cnt     <= '0;
        cpu_clk <= ~cpu_clk;
        cpu_ce  <= ~cpu_clk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef CPU_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;
  always_ff @(posedge clk) begin
    if (reset) cyc_cnt <= '0;
    else if (cpu_ce) cyc_cnt <= cyc_cnt + 32'd1;
  end
  assign cpu_cycles = cyc_cnt;
`else
  assign cpu_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: reset, ratio reloads, halt, debounced step, cycle counter.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  half_in;
  logic        half_load;
  logic [1:0]  mode;
  logic        step_btn;
  logic        cpu_clk;
  logic        cpu_ce;
  logic        halted;
  logic [31:0] cpu_cycles;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int ce_cnt   = 0;
  int hi_cnt   = 0;
  int ce_dbl   = 0;
  int cyc_nz   = 0;
  logic prev_ce = 1'b0;
  int n;

  cpu_clk_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .half_in    (half_in),
    .half_load  (half_load),
    .mode       (mode),
    .step_btn   (step_btn),
    .cpu_clk    (cpu_clk),
    .cpu_ce     (cpu_ce),
    .halted     (halted),
    .cpu_cycles (cpu_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (prev_ce && cpu_ce) ce_dbl++;
    prev_ce = cpu_ce;
    if (cpu_ce) ce_cnt++;
    if (cpu_clk) hi_cnt++;
`ifndef CPU_CYCLE_COUNT_EN
    if (cpu_cycles != 32'd0) cyc_nz++;
`endif
  endtask

  task automatic wait_lvl(input logic lvl, input int max, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (cpu_clk !== lvl && cycles < max);
  endtask

  task automatic load_half(input logic [7:0] v);
    half_in   = v;
    half_load = 1'b1;
    tick();
    half_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; half_in = '0; half_load = 1'b0; mode = 2'b00; step_btn = 1'b0;
    repeat (3) tick();
    check("rst_clk", cpu_clk, 0);
    check("rst_ce", cpu_ce, 0);
    check("rst_halted", halted, 1);
    check("rst_cycles", cpu_cycles, 0);

    reset = 1'b0;
    tick(); check("e1_halted", halted, 0); check("e1_clk", cpu_clk, 0);
    tick(); check("e2_clk", cpu_clk, 1); check("e2_ce", cpu_ce, 1);
    tick(); check("e3_clk", cpu_clk, 1); check("e3_ce", cpu_ce, 0);
    tick(); check("e4_clk", cpu_clk, 0);
    wait_lvl(1'b1, 20, n); check("div4_low", n, 2); check("div4_ce", cpu_ce, 1);

    // Load 5 one cycle into the high half; current high half keeps length 2.
    load_half(8'd5);
    tick(); check("ld5_fall", cpu_clk, 0);
    wait_lvl(1'b1, 20, n); check("h5_low", n, 5); check("h5_ce", cpu_ce, 1);
    wait_lvl(1'b0, 20, n); check("h5_high", n, 5);

    load_half(8'd0);
    wait_lvl(1'b1, 20, n); check("h0_old_low", n, 4);
    wait_lvl(1'b0, 20, n); check("h0_old_high", n, 5);
    wait_lvl(1'b1, 20, n); check("h0_low", n, 1);
    wait_lvl(1'b0, 20, n); check("h0_high", n, 1);

    load_half(8'd2);
    tick();
    wait_lvl(1'b1, 20, n); check("h2_low", n, 2);

    // Halt one cycle into the high half.
    mode = 2'b01;
    tick(); check("halt_still_high", cpu_clk, 1);
    tick(); check("halt_fall", cpu_clk, 0); check("halt_not_yet", halted, 0);
    tick(); check("halt_parked", halted, 1);
    ce_cnt = 0; hi_cnt = 0;
    repeat (12) tick();
    check("halt_no_ce", ce_cnt, 0);
    check("halt_no_high", hi_cnt, 0);
    check("halt_stays", halted, 1);

    mode = 2'b00;
    tick(); check("resume_halted", halted, 0); check("resume_clk", cpu_clk, 0);
    wait_lvl(1'b1, 20, n); check("resume_rise", n, 1);

    // Step mode: finish the running period, park, then bouncing press.
    mode = 2'b10;
    repeat (3) tick();
    check("step_parked", halted, 1);
    ce_cnt = 0; hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_btn = ~i[0];
      tick();
    end
    step_btn = 1'b1;
    repeat (40) tick();
    check("step1_ce", ce_cnt, 1);
    check("step1_high", hi_cnt, 2);
    check("step1_parked", halted, 1);

    step_btn = 1'b0;
    repeat (20) tick();
    load_half(8'd30);
    tick();
    step_btn = 1'b1;
    ce_cnt = 0;
    n = 0;
    while (ce_cnt == 0 && n < 30) begin
      tick();
      n++;
    end
    check("step2_start", ce_cnt, 1);
    ce_cnt = 0; hi_cnt = 0;
    step_btn = 1'b0;
    repeat (20) tick();
    step_btn = 1'b1;
    repeat (60) tick();
    check("step2_drop", ce_cnt, 0);
    check("step2_high", hi_cnt, 29);
    check("step2_parked", halted, 1);

    load_half(8'd5);
    tick();
    step_btn = 1'b0;
    repeat (20) tick();
    ce_cnt = 0; hi_cnt = 0;
    step_btn = 1'b1;
    repeat (40) tick();
    check("step3_ce", ce_cnt, 1);
    check("step3_high", hi_cnt, 5);
    check("step3_parked", halted, 1);

    // Reset in the middle of a high half restores half_reg=2.
    mode = 2'b00;
    wait_lvl(1'b1, 20, n); check("h5_resume", n, 5);
    tick();
    reset = 1'b1;
    tick();
    check("mrst_clk", cpu_clk, 0); check("mrst_ce", cpu_ce, 0); check("mrst_halted", halted, 1);
    reset = 1'b0;
    tick(); check("mrst_e1", cpu_clk, 0);
    tick(); check("mrst_e2", cpu_clk, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (400) tick();
`ifdef CPU_CYCLE_COUNT_EN
    check("cycles_100", cpu_cycles, 100);
`else
    check("cycles_zero", cpu_cycles, 0);
    check("cycles_never_nz", cyc_nz, 0);
`endif
    check("ce_never_double", ce_dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
